// File: rtl/parity_count_sequencer.sv
// Round sequencer for an odd/even counter datapath.
// Drives mode/enable/clear and keeps a cycle-exact shadow of the counter value.
module parity_count_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             start,
    input  logic [LEN_W-1:0] even_len,
    input  logic [LEN_W-1:0] odd_len,
    input  logic [LEN_W-1:0] rounds,
    output logic             busy,
    output logic             done,
    output logic             M,
    output logic             dp_en,
    output logic             dp_clear_n,
    output logic [WIDTH-1:0] Q,
    output logic [LEN_W-1:0] remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVEN,
        S_ODD,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] L_ZERO  = '0;
    localparam logic [LEN_W-1:0] L_ONE   = LEN_W'(1);
    localparam logic [WIDTH-1:0] Q_TWO   = WIDTH'(2);
    localparam logic [WIDTH-2:0] IDX_ONE = (WIDTH-1)'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-2:0] idx_q, idx_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] rnd_q, rnd_d;
    logic [LEN_W-1:0] elen_q, elen_d;
    logic [LEN_W-1:0] olen_q, olen_d;
    logic [LEN_W-1:0] rlen_q, rlen_d;

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            rnd_q   <= '0;
            elen_q  <= '0;
            olen_q  <= '0;
            rlen_q  <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            rnd_q   <= rnd_d;
            elen_q  <= elen_d;
            olen_q  <= olen_d;
            rlen_q  <= rlen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        rnd_d   = rnd_q;
        elen_d  = elen_q;
        olen_d  = olen_q;
        rlen_d  = rlen_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    elen_d  = even_len;
                    olen_d  = odd_len;
                    rlen_d  = rounds;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                q_d   = '0;
                idx_d = '0;
                rnd_d = rlen_q;
                if (rlen_q == L_ZERO || (elen_q == L_ZERO && olen_q == L_ZERO)) begin
                    rem_d   = '0;
                    state_d = S_DONE;
                end else if (elen_q != L_ZERO) begin
                    rem_d   = elen_q;
                    state_d = S_EVEN;
                end else begin
                    rem_d   = olen_q;
                    state_d = S_ODD;
                end
            end
            S_EVEN: begin
                q_d   = q_q + Q_TWO;
                rem_d = rem_q - L_ONE;
                if (rem_q == L_ONE) begin
                    if (olen_q != L_ZERO) begin
                        rem_d   = olen_q;
                        state_d = S_ODD;
                    end else begin
                        rnd_d = rnd_q - L_ONE;
                        if (rnd_q == L_ONE) begin
                            state_d = S_DONE;
                        end else begin
                            rem_d = elen_q;
                        end
                    end
                end
            end
            S_ODD: begin
                q_d   = {idx_q, 1'b1};
                idx_d = idx_q + IDX_ONE;
                rem_d = rem_q - L_ONE;
                if (rem_q == L_ONE) begin
                    rnd_d = rnd_q - L_ONE;
                    if (rnd_q == L_ONE) begin
                        state_d = S_DONE;
                    end else if (elen_q != L_ZERO) begin
                        rem_d   = elen_q;
                        state_d = S_EVEN;
                    end else begin
                        rem_d = olen_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign M          = (state_q == S_ODD);
    assign dp_en      = (state_q == S_EVEN) || (state_q == S_ODD);
    assign dp_clear_n = (state_q != S_LOAD);
    assign Q          = q_q;
    assign remaining  = rem_q;

endmodule

// File: tb/tb_parity_count_sequencer.sv
// Bench for parity_count_sequencer: directed table, corner sequences and
// random commands against a per-cycle trace model.
module tb_parity_count_sequencer;

    logic       Clock = 1'b0;
    logic       Clear = 1'b0;
    logic       start = 1'b0;
    logic [3:0] even_len = '0;
    logic [3:0] odd_len = '0;
    logic [3:0] rounds = '0;
    logic       busy, done, M, dp_en, dp_clear_n;
    logic [3:0] Q, remaining;

    parity_count_sequencer #(.WIDTH(4), .LEN_W(4)) dut (
        .Clock(Clock), .Clear(Clear), .start(start),
        .even_len(even_len), .odd_len(odd_len), .rounds(rounds),
        .busy(busy), .done(done), .M(M), .dp_en(dp_en),
        .dp_clear_n(dp_clear_n), .Q(Q), .remaining(remaining)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       m;
        logic       en;
        logic       clr_n;
        logic [3:0] q;
        logic [3:0] rem;
    } obs_t;

    typedef struct {
        logic [3:0] e;
        logic [3:0] o;
        logic [3:0] r;
        int         final_q;
        int         cycles;
    } vec_t;

    obs_t       exp_q[$];
    logic [3:0] mdl_q = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected per-cycle trace from LOAD through the first IDLE cycle.
    task automatic build(input int e, input int o, input int r);
        int idx;
        exp_q.delete();
        exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mdl_q, 4'd0});
        mdl_q = '0;
        idx = 0;
        if (r != 0 && (e != 0 || o != 0)) begin
            for (int rr = 0; rr < r; rr++) begin
                for (int k = 0; k < e; k++) begin
                    exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, mdl_q, 4'(e - k)});
                    mdl_q = 4'((mdl_q + 2) % 16);
                end
                for (int k = 0; k < o; k++) begin
                    exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, mdl_q, 4'(o - k)});
                    mdl_q = 4'(((idx % 8) * 2) + 1);
                    idx++;
                end
            end
        end
        exp_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, mdl_q, 4'd0});
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mdl_q, 4'd0});
    endtask

    function automatic obs_t sample();
        obs_t s;
        s = '{busy, done, M, dp_en, dp_clear_n, Q, (dp_en ? remaining : 4'd0)};
        return s;
    endfunction

    task automatic run_cmd(input logic [3:0] e, input logic [3:0] o,
                           input logic [3:0] r, input bit glitch,
                           output int busy_n, output int done_n);
        busy_n = 0;
        done_n = 0;
        build(int'(e), int'(o), int'(r));
        @(posedge Clock);
        #1;
        start = 1'b1;
        even_len = e;
        odd_len = o;
        rounds = r;
        @(posedge Clock);
        #1;
        start = 1'b0;
        even_len = 4'($urandom_range(0, 15));
        odd_len = 4'($urandom_range(0, 15));
        rounds = 4'($urandom_range(0, 15));
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge Clock);
            if (glitch) start = (i == 2);
            check($sformatf("trace e%0d o%0d r%0d cyc%0d", e, o, r, i),
                  32'(sample()), 32'(exp_q[i]));
            if (busy) busy_n++;
            if (done) done_n++;
        end
        start = 1'b0;
    endtask

    vec_t vecs[8];
    int   bn, dn;

    initial begin
        vecs[0] = '{4'd3, 4'd2,  4'd1, 3, 7};
        vecs[1] = '{4'd2, 4'd2,  4'd2, 7, 10};
        vecs[2] = '{4'd0, 4'd3,  4'd1, 5, 5};
        vecs[3] = '{4'd5, 4'd7,  4'd0, 0, 2};
        vecs[4] = '{4'd0, 4'd0,  4'd3, 0, 2};
        vecs[5] = '{4'd9, 4'd0,  4'd1, 2, 11};
        vecs[6] = '{4'd0, 4'd10, 4'd1, 3, 12};
        vecs[7] = '{4'd1, 4'd1,  4'd3, 5, 8};

        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("reset_outputs", {busy, done, M, dp_en, dp_clear_n, Q},
              {5'b00001, 4'd0});
        Clear = 1'b1;
        repeat (5) begin
            @(negedge Clock);
            check("idle_hold", {busy, done, M, dp_en, dp_clear_n, Q},
                  {5'b00001, 4'd0});
        end

        foreach (vecs[i]) begin
            run_cmd(vecs[i].e, vecs[i].o, vecs[i].r, 1'b0, bn, dn);
            check($sformatf("busy_cycles v%0d", i), bn, vecs[i].cycles);
            check($sformatf("done_pulses v%0d", i), dn, 1);
            check($sformatf("final_q v%0d", i), Q, vecs[i].final_q);
        end

        run_cmd(4'd4, 4'd2, 4'd1, 1'b1, bn, dn);
        check("glitch_busy_cycles", bn, 8);
        check("glitch_final_q", Q, 3);

        // Abort in the middle of an odd phase.
        @(posedge Clock);
        #1;
        start = 1'b1;
        even_len = 4'd1;
        odd_len = 4'd3;
        rounds = 4'd1;
        @(posedge Clock);
        #1;
        start = 1'b0;
        repeat (3) @(negedge Clock);
        check("abort_in_odd", {M, dp_en}, 2'b11);
        Clear = 1'b0;
        @(negedge Clock);
        check("abort_idle", {busy, done, dp_en, dp_clear_n, Q},
              {4'b0001, 4'd0});
        Clear = 1'b1;
        dn = 0;
        repeat (6) begin
            @(negedge Clock);
            if (done || busy) dn++;
        end
        check("abort_no_done", dn, 0);
        mdl_q = '0;
        run_cmd(4'd3, 4'd2, 4'd1, 1'b0, bn, dn);
        check("after_abort_done", dn, 1);

        for (int t = 0; t < 25; t++) begin
            logic [3:0] e, o, r;
            e = 4'($urandom_range(0, 5));
            o = 4'($urandom_range(0, 5));
            r = 4'($urandom_range(0, 3));
            run_cmd(e, o, r, 1'($urandom_range(0, 1)), bn, dn);
            check($sformatf("rand_cycles %0d", t), bn,
                  (r == 0 || (e == 0 && o == 0)) ? 2 : 2 + r * (e + o));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
